rx_byte_fifo: RTL and testbench

- Buffering stage directly downstream of the UART receiver and upstream of the UART transmitter in the echo path.
- Captures each byte strobed out by the receiver into a circular FIFO.
- Drains the FIFO into the transmitter with a start/ready handshake, so back-to-back received characters are echoed in order without loss while the transmitter is busy.

---
 rtl/rx_byte_fifo_pkg.sv | 19 +
 rtl/rx_byte_fifo_if.sv | 31 +++
 rtl/rx_byte_fifo_mem.sv | 38 +++
 rtl/rx_byte_fifo.sv | 143 ++++++++++++++
 tb/tb_rx_byte_fifo.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rx_byte_fifo_pkg.sv
// Shared definitions for the receive-to-transmit echo buffer:
// drain FSM encodings and the default FIFO depth.
package rx_byte_fifo_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } drain_state_e;

  // Any state other than IDLE means a byte is in flight to the transmitter.
  function automatic logic state_is_busy(input drain_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/rx_byte_fifo_if.sv
// Receiver strobe, transmitter handshake and status bundle of the echo buffer.
// slave: the FIFO itself; master: whatever drives the receiver/transmitter side.
interface rx_byte_fifo_if
  import rx_byte_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
);

  logic                rcv;
  logic [7:0]          data;
  logic                tx_ready;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                ovf_clr;
  logic                busy;

  modport slave (
    input  rcv, data, tx_ready, ovf_clr,
    output tx_start, tx_data, empty, full, level, overflow, busy
  );

  modport master (
    output rcv, data, tx_ready, ovf_clr,
    input  tx_start, tx_data, empty, full, level, overflow, busy
  );

endinterface

// File: rtl/rx_byte_fifo_mem.sv
// Byte storage for the echo FIFO: one synchronous write port and a
// combinational read port. Contents are not reset.
module fifo_mem #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Next array contents: only the addressed entry changes on a write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Register the array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// Echo-path buffer between the UART receiver and transmitter. Received bytes
// are queued in a circular FIFO and handed to the transmitter one at a time
// with a start/ready handshake.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | nothing in flight; pops a byte when FIFO non-empty & tx ready
// ST_START     | tx_start pulse for this single cycle, tx_data valid
// ST_WAIT_BUSY | waiting for the transmitter to accept (tx_ready falls)
// ST_WAIT_DONE | waiting for the transmitter to finish (tx_ready rises)
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic           clk,
  input  logic           rstn,
  rx_byte_fifo_if.slave  bus
);

  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  drain_state_e          state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [7:0]            rd_data;
  logic                  push;
  logic                  pop;
  logic                  drop;

  fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Handshake decisions. A pop frees a slot in the same cycle, so a full FIFO
  // still accepts a byte when the drain FSM is popping.
  always_comb begin
    pop  = (state_q == ST_IDLE) && !empty_q && bus.tx_ready;
    push = bus.rcv && (!full_q || pop);
    drop = bus.rcv && full_q && !pop;
  end

  // Pointers, occupancy and status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
      default: level_d = level_q;
    endcase

    empty_d = (level_d == '0);
    full_d  = (level_d == LEVEL_FULL);

    // A drop in the same cycle as a clear wins, so the loss is never hidden.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Drain FSM next state; outputs are derived from the next state so they
  // are registered alongside it.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_data_d = rd_data;
          state_d   = ST_START;
        end
      end
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!bus.tx_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.tx_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    tx_start_d = (state_d == ST_START);
    busy_d     = state_is_busy(state_d);
  end

  // State registers; reset discards all buffered data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Bench for rx_byte_fifo: directed receive traffic, a simple transmitter
// model, and a scoreboard of expected echoed bytes checked on every tx_start.
module tb_rx_byte_fifo;

  logic clk;
  logic rstn;
  logic hold;
  int   model_cnt;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   n_starts;
  int   start_cyc;
  bit   prev_start;
  logic [7:0] exp_q [$];

  rx_byte_fifo_if #(.DEPTH_LOG2(4)) bus ();

  rx_byte_fifo #(.DEPTH_LOG2(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: after seeing tx_start it goes busy for 10 cycles.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)              model_cnt <= 0;
    else if (bus.tx_start)  model_cnt <= 10;
    else if (model_cnt != 0) model_cnt <= model_cnt - 1;
  end

  assign bus.tx_ready = !hold && (model_cnt == 0);

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.tx_start) begin
        n_starts++;
        start_cyc = cyc;
        vectors++;
        if (prev_start) begin
          miscompares++;
          $display("FAIL start_width: tx_start high 2 cycles, required 1");
        end
        vectors++;
        if (model_cnt != 0) begin
          miscompares++;
          $display("FAIL start_while_busy: tx busy count %0d, required 0", model_cnt);
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_start: tx_data %02h with no byte expected", bus.tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.tx_data !== e) begin
            miscompares++;
            $display("FAIL tx_data: got %02h, required %02h", bus.tx_data, e);
          end
        end
      end
      prev_start = bus.tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b, input bit expect_out);
    bus.rcv  = 1'b1;
    bus.data = b;
    if (expect_out) exp_q.push_back(b);
    @(negedge clk);
    bus.rcv  = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n_starts, target);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(!bus.busy && bus.empty && model_cnt == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s: still busy=%0d empty=%0d after %0d cycles", name, bus.busy, bus.empty, budget);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, int'(bus.empty), 1);
    chk({tag, "_full"}, int'(bus.full), 0);
    chk({tag, "_level"}, int'(bus.level), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
    chk({tag, "_tx_start"}, int'(bus.tx_start), 0);
    chk({tag, "_tx_data"}, int'(bus.tx_data), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rcv_cyc;
    vectors = 0; miscompares = 0; n_starts = 0; cyc = 0; start_cyc = 0;
    prev_start = 1'b0;
    rstn = 1'b0; hold = 1'b0;
    bus.rcv = 1'b0; bus.data = 8'h00; bus.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rstn = 1'b1;
    @(negedge clk);

    // Single byte: 2-cycle latency, busy through the transfer.
    base = n_starts;
    rcv_cyc = cyc;
    rx(8'h55, 1'b1);
    chk("single_empty", int'(bus.empty), 0);
    wait_starts(base + 1, 10, "single_start");
    chk("single_latency", start_cyc - rcv_cyc, 2);
    @(negedge clk);
    while (!bus.tx_ready) begin
      chk("single_busy", int'(bus.busy), 1);
      @(negedge clk);
    end
    wait_idle(10, "single_idle");
    chk("single_level", int'(bus.level), 0);

    // Burst while transmitter busy, then ordered drain.
    hold = 1'b1;
    rx(8'h4B, 1'b1);
    rx(8'h4F, 1'b1);
    rx(8'h21, 1'b1);
    chk("burst_level", int'(bus.level), 3);
    chk("burst_busy", int'(bus.busy), 0);
    base = n_starts;
    hold = 1'b0;
    wait_starts(base + 3, 100, "burst_starts");
    wait_idle(30, "burst_idle");

    // Overflow: 17th byte dropped, sticky flag, clear.
    hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        chk("ovf_full16", int'(bus.full), 1);
        chk("ovf_level16", int'(bus.level), 16);
        chk("ovf_flag16", int'(bus.overflow), 0);
      end
      rx(8'(i), i < 16);
    end
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_level", int'(bus.level), 16);
    @(negedge clk);
    chk("ovf_sticky", int'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", int'(bus.overflow), 0);
    base = n_starts;
    hold = 1'b0;
    wait_starts(base + 16, 400, "ovf_drain");
    wait_idle(30, "ovf_idle");
    chk("ovf_level_end", int'(bus.level), 0);

    // Full FIFO with push and pop in the same cycle.
    hold = 1'b1;
    for (int i = 0; i < 16; i++) rx(8'h30 + 8'(i), 1'b1);
    chk("pp_full_before", int'(bus.full), 1);
    base = n_starts;
    hold = 1'b0;
    rx(8'hA5, 1'b1);
    chk("pp_level", int'(bus.level), 16);
    chk("pp_full", int'(bus.full), 1);
    chk("pp_overflow", int'(bus.overflow), 0);
    chk("pp_busy", int'(bus.busy), 1);
    wait_starts(base + 17, 450, "pp_drain");
    wait_idle(30, "pp_idle");

    // Reset during WAIT_DONE with 5 bytes still queued.
    hold = 1'b1;
    for (int i = 0; i < 6; i++) rx(8'h60 + 8'(i), i == 0);
    base = n_starts;
    hold = 1'b0;
    wait_starts(base + 1, 10, "mid_first_start");
    repeat (3) @(negedge clk);
    chk("mid_level", int'(bus.level), 5);
    chk("mid_busy", int'(bus.busy), 1);
    rstn = 1'b0;
    #1;
    chk_reset("mid");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    base = n_starts;
    repeat (20) @(negedge clk);
    chk("mid_no_start", n_starts, base);
    rx(8'h77, 1'b1);
    wait_starts(base + 1, 10, "mid_new_start");
    wait_idle(30, "mid_idle");

    chk("scoreboard_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
